// File: rtl/letc_core_stage_writeback_q.sv
// LETC core writeback stage: resolves rd at enqueue, buffers writes in a small retire
// queue, and shares the single register-file write port with a long-latency unit.
module letc_core_stage_writeback_q #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH       = 2,
  parameter bit          LP_PRIORITY = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            w_stall,
  input  logic            w_flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_rd_idx,
  input  logic            in_rd_we,
  input  logic [1:0]      in_rd_src,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_mem_rdata,
  input  logic [1:0]      in_mem_addr_lo,
  input  logic [1:0]      in_mem_size,
  input  logic            in_mem_unsigned,
  input  logic [XLEN-1:0] in_csr_old_val,
  input  logic            lp_valid,
  output logic            lp_ready,
  input  logic [4:0]      lp_rd_idx,
  input  logic [XLEN-1:0] lp_rd_val,
  output logic            rf_rd_we,
  output logic [4:0]      rf_rd_idx,
  output logic [XLEN-1:0] rf_rd_val,
  input  logic [4:0]      fwd_idx,
  output logic            fwd_hit,
  output logic [XLEN-1:0] fwd_val,
  output logic            wb_idle
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  // rd_src encodings shared with letc_core_pkg
  localparam logic [1:0] RdSrcAlu = 2'd0;
  localparam logic [1:0] RdSrcMem = 2'd1;
  localparam logic [1:0] RdSrcCsr = 2'd2;

  localparam logic [XLEN-1:0] Poison = XLEN'(32'hDEADBEEF);

  logic [4:0]      idx_q [DEPTH];
  logic [XLEN-1:0] val_q [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic            full;
  logic            head_valid;
  logic            accept;
  logic            push;
  logic            pop;
  logic            take_lp;
  logic [XLEN-1:0] mem_sh;
  logic [XLEN-1:0] mem_val;
  logic [XLEN-1:0] enq_val;
  logic [PtrW-1:0] fwd_pos;

  assign full       = (count_q == CntW'(DEPTH));
  assign head_valid = (count_q != '0);
  assign wb_idle    = (count_q == '0);

  // Gated by rst_n so the handshake is closed for the whole reset interval.
  assign in_ready = rst_n && !full && !w_stall;
  assign accept   = in_valid && in_ready && !w_flush;
  assign push     = accept && in_rd_we && (in_rd_idx != 5'd0);

  // Load alignment and extension
  always_comb begin
    mem_sh  = in_mem_rdata >> {in_mem_addr_lo, 3'b000};
    mem_val = Poison;
    case (in_mem_size)
      2'd0: mem_val = in_mem_unsigned ? {{(XLEN-8){1'b0}}, mem_sh[7:0]}
                                      : {{(XLEN-8){mem_sh[7]}}, mem_sh[7:0]};
      2'd1: mem_val = in_mem_unsigned ? {{(XLEN-16){1'b0}}, mem_sh[15:0]}
                                      : {{(XLEN-16){mem_sh[15]}}, mem_sh[15:0]};
      2'd2: mem_val = in_mem_rdata;
      default: mem_val = Poison;
    endcase
  end

  always_comb begin
    enq_val = Poison;
    case (in_rd_src)
      RdSrcAlu: enq_val = in_alu_result;
      RdSrcMem: enq_val = mem_val;
      RdSrcCsr: enq_val = in_csr_old_val;
      default:  enq_val = Poison;
    endcase
  end

  // RF port arbitration between queue head and LP unit
  always_comb begin
    take_lp = 1'b0;
    pop     = 1'b0;
    if (rst_n && !w_stall) begin
      if (LP_PRIORITY) begin
        if (lp_valid)        take_lp = 1'b1;
        else if (head_valid) pop     = 1'b1;
      end else begin
        if (head_valid)      pop     = 1'b1;
        else if (lp_valid)   take_lp = 1'b1;
      end
    end
  end

  always_comb begin
    lp_ready  = take_lp;
    rf_rd_we  = 1'b0;
    rf_rd_idx = 5'd0;
    rf_rd_val = '0;
    if (take_lp && (lp_rd_idx != 5'd0)) begin
      rf_rd_we  = 1'b1;
      rf_rd_idx = lp_rd_idx;
      rf_rd_val = lp_rd_val;
    end else if (pop) begin
      rf_rd_we  = 1'b1;
      rf_rd_idx = idx_q[rd_ptr_q];
      rf_rd_val = val_q[rd_ptr_q];
    end
  end

  always_comb begin
    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Scan oldest to youngest so the last match wins; the enqueuing entry is not yet visible.
  always_comb begin
    fwd_hit = 1'b0;
    fwd_val = '0;
    fwd_pos = rd_ptr_q;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      fwd_pos = rd_ptr_q + PtrW'(k);
      if (rst_n && (CntW'(k) < count_q) && (fwd_idx != 5'd0) && (idx_q[fwd_pos] == fwd_idx)) begin
        fwd_hit = 1'b1;
        fwd_val = val_q[fwd_pos];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        idx_q[k] <= 5'd0;
        val_q[k] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (push) begin
        idx_q[wr_ptr_q] <= in_rd_idx;
        val_q[wr_ptr_q] <= enq_val;
      end
    end
  end

  no_push_when_full : assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
  no_pop_when_empty : assert property (@(posedge clk) disable iff (!rst_n) !(pop && !head_valid));

endmodule

// File: tb/tb_letc_core_stage_writeback_q.sv
// Directed bench for letc_core_stage_writeback_q (XLEN=32, DEPTH=2, LP_PRIORITY=1).
module tb_letc_core_stage_writeback_q;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        w_stall, w_flush;
  logic        in_valid, in_ready;
  logic [4:0]  in_rd_idx;
  logic        in_rd_we;
  logic [1:0]  in_rd_src;
  logic [31:0] in_alu_result, in_mem_rdata, in_csr_old_val;
  logic [1:0]  in_mem_addr_lo, in_mem_size;
  logic        in_mem_unsigned;
  logic        lp_valid, lp_ready;
  logic [4:0]  lp_rd_idx;
  logic [31:0] lp_rd_val;
  logic        rf_rd_we;
  logic [4:0]  rf_rd_idx;
  logic [31:0] rf_rd_val;
  logic [4:0]  fwd_idx;
  logic        fwd_hit;
  logic [31:0] fwd_val;
  logic        wb_idle;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  letc_core_stage_writeback_q #(
    .XLEN       (32),
    .DEPTH      (2),
    .LP_PRIORITY(1'b1)
  ) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .w_stall        (w_stall),
    .w_flush        (w_flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_rd_idx      (in_rd_idx),
    .in_rd_we       (in_rd_we),
    .in_rd_src      (in_rd_src),
    .in_alu_result  (in_alu_result),
    .in_mem_rdata   (in_mem_rdata),
    .in_mem_addr_lo (in_mem_addr_lo),
    .in_mem_size    (in_mem_size),
    .in_mem_unsigned(in_mem_unsigned),
    .in_csr_old_val (in_csr_old_val),
    .lp_valid       (lp_valid),
    .lp_ready       (lp_ready),
    .lp_rd_idx      (lp_rd_idx),
    .lp_rd_val      (lp_rd_val),
    .rf_rd_we       (rf_rd_we),
    .rf_rd_idx      (rf_rd_idx),
    .rf_rd_val      (rf_rd_val),
    .fwd_idx        (fwd_idx),
    .fwd_hit        (fwd_hit),
    .fwd_val        (fwd_val),
    .wb_idle        (wb_idle)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    in_valid        = 1'b0;
    in_rd_we        = 1'b0;
    in_rd_idx       = 5'd0;
    in_rd_src       = 2'd0;
    in_alu_result   = '0;
    in_mem_rdata    = '0;
    in_mem_addr_lo  = 2'd0;
    in_mem_size     = 2'd0;
    in_mem_unsigned = 1'b0;
    in_csr_old_val  = '0;
  endtask

  task automatic drive_in(input logic [4:0] idx, input logic [1:0] src, input logic [31:0] alu,
                          input logic [31:0] rdata, input logic [1:0] lo, input logic [1:0] size,
                          input logic uns);
    in_valid        = 1'b1;
    in_rd_we        = 1'b1;
    in_rd_idx       = idx;
    in_rd_src       = src;
    in_alu_result   = alu;
    in_mem_rdata    = rdata;
    in_mem_addr_lo  = lo;
    in_mem_size     = size;
    in_mem_unsigned = uns;
    in_csr_old_val  = 32'h1234_5678;
  endtask

  task automatic drive_lp(input logic v, input logic [4:0] idx, input logic [31:0] val);
    lp_valid  = v;
    lp_rd_idx = idx;
    lp_rd_val = val;
  endtask

  task automatic check_wr(input string tag, input logic we, input logic [4:0] idx,
                          input logic [31:0] val);
    check_eq({tag, "_we"}, {31'd0, rf_rd_we}, {31'd0, we});
    check_eq({tag, "_idx"}, {27'd0, rf_rd_idx}, {27'd0, idx});
    check_eq({tag, "_val"}, rf_rd_val, val);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    w_stall = 1'b0;
    w_flush = 1'b0;
    fwd_idx = 5'd0;
    clr_in();
    drive_lp(1'b0, 5'd0, 32'd0);
    lp_valid = 1'b1;
    lp_rd_idx = 5'd9;
    #2;
    // Reset: outputs quiet even with lp_valid asserted.
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check_eq("rst_wb_idle", {31'd0, wb_idle}, 32'd1);
    check_eq("rst_lp_ready", {31'd0, lp_ready}, 32'd0);
    check_eq("rst_fwd_hit", {31'd0, fwd_hit}, 32'd0);
    check_wr("rst_rf", 1'b0, 5'd0, 32'd0);
    drive_lp(1'b0, 5'd0, 32'd0);
    #20 rst_n = 1'b1;
    step();
    check_eq("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Signed byte load at addr_lo=3
    drive_in(5'd7, 2'd1, 32'd0, 32'h80FF_1234, 2'd3, 2'd0, 1'b0);
    #1 check_wr("sb_same_cycle", 1'b0, 5'd0, 32'd0);
    step(); clr_in();
    #1 check_wr("sb", 1'b1, 5'd7, 32'hFFFF_FF80);
    check_eq("sb_not_idle", {31'd0, wb_idle}, 32'd0);
    step();
    check_eq("sb_idle_after", {31'd0, wb_idle}, 32'd1);

    // Unsigned half, then size 3 poison, then CSR, back to back
    drive_in(5'd3, 2'd1, 32'd0, 32'hBEEF_0000, 2'd2, 2'd1, 1'b1);
    step();
    drive_in(5'd4, 2'd1, 32'd0, 32'hBEEF_0000, 2'd2, 2'd3, 1'b0);
    #1 check_wr("lhu", 1'b1, 5'd3, 32'h0000_BEEF);
    step();
    drive_in(5'd6, 2'd2, 32'hFFFF_FFFF, 32'd0, 2'd0, 2'd0, 1'b0);
    #1 check_wr("size3", 1'b1, 5'd4, 32'hDEAD_BEEF);
    step(); clr_in();
    #1 check_wr("csr", 1'b1, 5'd6, 32'h1234_5678);
    step();

    // Contention: LP wins for 3 cycles while x1, x2 queue up
    drive_lp(1'b1, 5'd10, 32'hA0);
    drive_in(5'd1, 2'd0, 32'h11, 32'd0, 2'd0, 2'd0, 1'b0);
    #1 check_wr("lp0", 1'b1, 5'd10, 32'hA0);
    check_eq("lp0_ready", {31'd0, lp_ready}, 32'd1);
    step();
    drive_lp(1'b1, 5'd11, 32'hA1);
    drive_in(5'd2, 2'd0, 32'h22, 32'd0, 2'd0, 2'd0, 1'b0);
    #1 check_eq("c2_in_ready", {31'd0, in_ready}, 32'd1);
    check_wr("lp1", 1'b1, 5'd11, 32'hA1);
    step(); clr_in();
    drive_lp(1'b1, 5'd12, 32'hA2);
    fwd_idx = 5'd1;
    #1 check_eq("c3_in_ready", {31'd0, in_ready}, 32'd0);
    check_wr("lp2", 1'b1, 5'd12, 32'hA2);
    check_eq("c3_fwd_hit", {31'd0, fwd_hit}, 32'd1);
    check_eq("c3_fwd_val", fwd_val, 32'h11);
    step();
    drive_lp(1'b0, 5'd0, 32'd0);
    #1 check_wr("q_x1", 1'b1, 5'd1, 32'h11);
    check_eq("q_x1_lp_ready", {31'd0, lp_ready}, 32'd0);
    step();
    check_wr("q_x2", 1'b1, 5'd2, 32'h22);
    step();
    check_wr("q_empty", 1'b0, 5'd0, 32'd0);
    check_eq("q_idle", {31'd0, wb_idle}, 32'd1);

    // Forwarding under the same contention: x5=1 then x5=2
    fwd_idx = 5'd5;
    drive_lp(1'b1, 5'd20, 32'hB0);
    drive_in(5'd5, 2'd0, 32'd1, 32'd0, 2'd0, 2'd0, 1'b0);
    #1 check_eq("fwd_enq_not_seen", {31'd0, fwd_hit}, 32'd0);
    step();
    drive_in(5'd5, 2'd0, 32'd2, 32'd0, 2'd0, 2'd0, 1'b0);
    #1 check_eq("fwd_one_val", fwd_val, 32'd1);
    step(); clr_in();
    #1 check_eq("fwd_two_hit", {31'd0, fwd_hit}, 32'd1);
    check_eq("fwd_two_val", fwd_val, 32'd2);
    fwd_idx = 5'd0;
    #1 check_eq("fwd_x0_hit", {31'd0, fwd_hit}, 32'd0);
    fwd_idx = 5'd9;
    #1 check_eq("fwd_miss_hit", {31'd0, fwd_hit}, 32'd0);
    check_eq("fwd_miss_val", fwd_val, 32'd0);
    fwd_idx = 5'd5;
    step();
    drive_lp(1'b0, 5'd0, 32'd0);
    #1 check_wr("fwd_drain1", 1'b1, 5'd5, 32'd1);
    check_eq("fwd_drain1_val", fwd_val, 32'd2);
    step();
    check_wr("fwd_drain2", 1'b1, 5'd5, 32'd2);
    check_eq("fwd_popping_hit", {31'd0, fwd_hit}, 32'd1);
    step();
    check_eq("fwd_after_hit", {31'd0, fwd_hit}, 32'd0);
    fwd_idx = 5'd0;

    // Flush kills the input
    drive_in(5'd8, 2'd0, 32'h55, 32'd0, 2'd0, 2'd0, 1'b0);
    w_flush = 1'b1;
    step(); clr_in(); w_flush = 1'b0;
    #1 check_eq("flush_we", {31'd0, rf_rd_we}, 32'd0);
    check_eq("flush_idle", {31'd0, wb_idle}, 32'd1);

    // rd=0 accepted but dropped
    drive_in(5'd0, 2'd0, 32'h77, 32'd0, 2'd0, 2'd0, 1'b0);
    step(); clr_in();
    #1 check_eq("x0_we", {31'd0, rf_rd_we}, 32'd0);
    check_eq("x0_idle", {31'd0, wb_idle}, 32'd1);

    // Stall holds a queued entry and blocks the LP unit
    drive_in(5'd6, 2'd0, 32'h66, 32'd0, 2'd0, 2'd0, 1'b0);
    step(); clr_in();
    w_stall = 1'b1;
    drive_lp(1'b1, 5'd9, 32'h99);
    for (int i = 0; i < 2; i++) begin
      #1 check_eq("stall_we", {31'd0, rf_rd_we}, 32'd0);
      check_eq("stall_lp_ready", {31'd0, lp_ready}, 32'd0);
      check_eq("stall_in_ready", {31'd0, in_ready}, 32'd0);
      step();
    end
    w_stall = 1'b0;
    drive_lp(1'b0, 5'd0, 32'd0);
    #1 check_wr("unstall", 1'b1, 5'd6, 32'h66);
    step();
    check_eq("unstall_idle", {31'd0, wb_idle}, 32'd1);

    // Asynchronous reset with two entries queued
    drive_lp(1'b1, 5'd13, 32'hC0);
    drive_in(5'd1, 2'd0, 32'h31, 32'd0, 2'd0, 2'd0, 1'b0);
    step();
    drive_in(5'd2, 2'd0, 32'h32, 32'd0, 2'd0, 2'd0, 1'b0);
    step(); clr_in();
    drive_lp(1'b0, 5'd0, 32'd0);
    #1 check_wr("pre_rst", 1'b1, 5'd1, 32'h31);
    #1 rst_n = 1'b0;
    #1 check_wr("mid_rst", 1'b0, 5'd0, 32'd0);
    check_eq("mid_rst_idle", {31'd0, wb_idle}, 32'd1);
    check_eq("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check_eq("post_rst_we", {31'd0, rf_rd_we}, 32'd0);
      check_eq("post_rst_idle", {31'd0, wb_idle}, 32'd1);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/letc_core_stage_writeback_q.md
Name: letc_core_stage_writeback_q

Overview:
Parametrised writeback stage for the LETC core. It accepts retiring M2 results over a valid/ready handshake and resolves the rd value at enqueue, including load byte/halfword alignment and sign/zero extension. Resolved writes sit in a DEPTH-entry retire queue that shares the single register-file write port with a long-latency unit (LP, e.g. divider). A forwarding lookup exposes queued-but-unwritten values to upstream bypass logic.

Parameters:
XLEN, 32, datapath width; must be 32 (0xDEADBEEF poison assumes it)
DEPTH, 2, retire queue entries; power of two, >= 2
LP_PRIORITY, 1, 1 = LP unit wins the RF port; 0 = queue head wins

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
w_stall  in  1  freeze stage: no accept, no drain, no LP accept
w_flush  in  1  kill the input offered this cycle
in_valid  in  1  M2 result valid
in_ready  out  1  stage can accept
in_rd_idx  in  5  destination register
in_rd_we  in  1  instruction writes rd
in_rd_src  in  2  RD_SRC_ALU / RD_SRC_MEM / RD_SRC_CSR encodings from letc_core_pkg
in_alu_result  in  XLEN  ALU result
in_mem_rdata  in  XLEN  raw aligned-word load data
in_mem_addr_lo  in  2  load address bits [1:0]
in_mem_size  in  2  0 byte, 1 half, 2 word
in_mem_unsigned  in  1  zero-extend load
in_csr_old_val  in  XLEN  CSR old value
lp_valid  in  1  LP result valid
lp_ready  out  1  LP result consumed this cycle
lp_rd_idx  in  5  LP destination
lp_rd_val  in  XLEN  LP value
rf_rd_we  out  1  RF write enable
rf_rd_idx  out  5  RF write index
rf_rd_val  out  XLEN  RF write data
fwd_idx  in  5  bypass lookup index
fwd_hit  out  1  a queued entry targets fwd_idx
fwd_val  out  XLEN  value of youngest matching entry
wb_idle  out  1  queue empty

Behaviour:
- Reset (async, rst_n low): queue count 0, read/write pointers 0; immediately and throughout reset rf_rd_we=0, lp_ready=0, fwd_hit=0, wb_idle=1, in_ready=0; rf_rd_idx/rf_rd_val/fwd_val=0. After release, in_ready=1 unless stalled.
- in_ready = (count < DEPTH) && !w_stall. Combinational, registered state only; no same-cycle pass-through when full.
- Accept = in_valid && in_ready && !w_flush. Accepted with in_rd_we=0 or in_rd_idx=0 -> handshake completes, nothing enqueued.
- Value resolution at enqueue: ALU -> in_alu_result; CSR -> in_csr_old_val; MEM -> sh = in_mem_rdata >> (8*addr_lo); size 0 -> sh[7:0], size 1 -> sh[15:8..0], size 2 -> full word (addr_lo ignored); byte/half sign-extended unless in_mem_unsigned. Invalid rd_src or size 3 -> 0xDEADBEEF.
- Drain: at most one RF write per cycle, combinational from state and LP inputs; none while w_stall.
  - LP_PRIORITY=1: lp_valid -> lp_ready=1, RF writes LP; else queue head (if any) written and popped.
  - LP_PRIORITY=0: queue nonempty -> head written and popped, lp_ready=0; queue empty and lp_valid -> lp_ready=1, LP written.
  - LP result with lp_rd_idx=0: lp_ready=1, rf_rd_we=0.
  - rf_rd_idx/val = 0 whenever rf_rd_we=0.
- Latency: accept in cycle N -> earliest rf_rd_we in cycle N+1. Queue is strictly FIFO; pointers wrap modulo DEPTH.
- Simultaneous enqueue and pop in one cycle: count unchanged. Pop on empty or push on full cannot occur.
- w_flush affects only the current input; entries already queued are committed and always drain.
- Forwarding (combinational): scan valid entries; fwd_hit=1 iff fwd_idx!=0 and some entry matches; fwd_val = youngest match, 0 on miss. The entry being popped this cycle still counts. The entry being enqueued this cycle does not count. LP inputs are not searched.
- wb_idle = (count == 0).

Test Plan:
- Signed byte: rd_src MEM, addr_lo=3, size 0, signed, mem_rdata=0x80FF1234, rd=7 -> next cycle rf_rd_we=1, idx 7, val 0xFFFFFF80.
- Unsigned half: addr_lo=2, size 1, unsigned, mem_rdata=0xBEEF0000, rd=3 -> rf_rd_val=0x0000BEEF. Size 3 -> 0xDEADBEEF.
- Contention, LP_PRIORITY=1, DEPTH=2: lp_valid high 3 cycles while ALU writes 0x11 (x1) and 0x22 (x2) accepted back-to-back -> in_ready=0 on cycle 3; LP values written first; then x1=0x11, x2=0x22 in order; wb_idle=1 afterwards.
- Forwarding: under the same contention, queue x5=1 then x5=2 -> fwd_idx=5 gives fwd_hit=1, fwd_val=2. fwd_idx=0 -> fwd_hit=0.
- Kill and drop:
  - in_valid with w_flush=1 -> no write, queue unchanged.
  - Accept with rd_idx=0 -> no write, wb_idle stays 1.
  - w_stall=1 with 1 entry queued -> rf_rd_we=0 and lp_ready=0 until stall drops.
- Reset mid-operation: 2 entries queued, rst_n low asynchronously -> rf_rd_we=0 that same cycle, wb_idle=1. No stale writes after rst_n returns high.
